condicionador_botoes: RTL and testbench

//  Input stage placed directly upstream of the game top level. Its outputs drive that top level's botoes input.

---
 rtl/condicionador_botoes_pkg.sv | 18 +
 rtl/sincronizador_2ff.sv | 23 ++
 rtl/condicionador_botoes.sv | 108 ++++++++++
 tb/tb_condicionador_botoes.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/condicionador_botoes_pkg.sv
// Shared constants for the push-button conditioner: FSM state codes,
// default sizing and a one-hot helper used when accepting a press.
package condicionador_botoes_pkg;

  localparam int N_BOTOES_PADRAO  = 4;
  localparam int DEBOUNCE_PADRAO  = 50000;

  // Codes shown on the debug display; the display decoder uses the same values.
  localparam logic [1:0] OCIOSO      = 2'd0;
  localparam logic [1:0] FILTRANDO   = 2'd1;
  localparam logic [1:0] PRESSIONADO = 2'd2;
  localparam logic [1:0] LIBERANDO   = 2'd3;

  function automatic logic eh_one_hot(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/sincronizador_2ff.sv
// Two-stage synchroniser for asynchronous level inputs, synchronous reset.
module sincronizador_2ff #(
  parameter int LARGURA = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [LARGURA-1:0] d,
  output logic [LARGURA-1:0] q
);

  logic [LARGURA-1:0] sync1;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= '0;
      q     <= '0;
    end else begin
      sync1 <= d;
      q     <= sync1;
    end
  end

endmodule

// File: rtl/condicionador_botoes.sv
// Push-button conditioner: synchronises and debounces the raw buttons and
// emits one pulse plus a held code per accepted single-button press.
//
//   state       | meaning
//   ------------+---------------------------------------------------------
//   OCIOSO      | no button down, waiting for a press
//   FILTRANDO   | candidate code in amostra, counting stable cycles
//   PRESSIONADO | press accepted (or rejected as multiple), waiting release
//   LIBERANDO   | all buttons up, counting stable cycles before idle
module condicionador_botoes
  import condicionador_botoes_pkg::*;
#(
  parameter int N_BOTOES        = N_BOTOES_PADRAO,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_PADRAO
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_BOTOES-1:0] botoes_raw,
  output logic [N_BOTOES-1:0] botoes_out,
  output logic                jogada_pulso,
  output logic                tem_botao,
  output logic                db_multipla,
  output logic [3:0]          db_estado
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [N_BOTOES-1:0] sync2;
  logic [N_BOTOES-1:0] amostra;
  logic [CW-1:0]       cnt;
  logic [1:0]          estado;
  logic                amostra_unica;

  sincronizador_2ff #(
    .LARGURA (N_BOTOES)
  ) u_sinc (
    .clock (clock),
    .reset (reset),
    .d     (botoes_raw),
    .q     (sync2)
  );

  assign amostra_unica = eh_one_hot(32'(amostra));

  // cnt stops at CNT_MAX, so it never wraps while a level is held.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado       <= OCIOSO;
      amostra      <= '0;
      cnt          <= '0;
      botoes_out   <= '0;
      jogada_pulso <= 1'b0;
      db_multipla  <= 1'b0;
    end else begin
      jogada_pulso <= 1'b0;
      db_multipla  <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (sync2 != '0) begin
            estado  <= FILTRANDO;
            amostra <= sync2;
            cnt     <= '0;
          end
        end
        FILTRANDO: begin
          if (sync2 == '0) begin
            estado <= OCIOSO;
          end else if (sync2 != amostra) begin
            amostra <= sync2;
            cnt     <= '0;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end else begin
            estado <= PRESSIONADO;
            if (amostra_unica) begin
              botoes_out   <= amostra;
              jogada_pulso <= 1'b1;
            end else begin
              db_multipla <= 1'b1;
            end
          end
        end
        PRESSIONADO: begin
          if (sync2 == '0) begin
            estado <= LIBERANDO;
            cnt    <= '0;
          end
        end
        LIBERANDO: begin
          if (sync2 != '0) begin
            estado <= PRESSIONADO;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end else begin
            estado <= OCIOSO;
          end
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

  // PRESSIONADO and LIBERANDO are exactly the codes with bit 1 set.
  assign tem_botao = estado[1];
  assign db_estado = {2'b00, estado};

endmodule

// File: tb/tb_condicionador_botoes.sv
// Self-checking bench for condicionador_botoes with DEBOUNCE_CYCLES=4 (latency 7 edges).
module tb_condicionador_botoes;

  typedef struct {
    logic [3:0] raw;
    int         rep;
    int         jog;
    int         mult;
    logic [3:0] out;
    logic       tem;
    logic [3:0] est;
  } seg_t;

  localparam int N_SEG = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] botoes_raw = 4'b0000;
  logic [3:0] botoes_out;
  logic       jogada_pulso;
  logic       tem_botao;
  logic       db_multipla;
  logic [3:0] db_estado;

  int n_checks = 0;
  int n_pass   = 0;
  int borda    = 0;
  int n_jog    = 0;
  int n_mult   = 0;
  int ult_jog  = 0;
  int n_overlap = 0;
  int n_est_bad = 0;

  seg_t tabela [N_SEG];
  seg_t fila [$];

  condicionador_botoes #(
    .N_BOTOES        (4),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .botoes_raw   (botoes_raw),
    .botoes_out   (botoes_out),
    .jogada_pulso (jogada_pulso),
    .tem_botao    (tem_botao),
    .db_multipla  (db_multipla),
    .db_estado    (db_estado)
  );

  always #5 clock = ~clock;

  task automatic checar(input string nome, input int atual, input int esperado);
    n_checks++;
    if (atual == esperado) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nome, atual, esperado);
  endtask

  task automatic ciclo(input logic r, input logic [3:0] raw);
    @(negedge clock);
    reset      = r;
    botoes_raw = raw;
    @(posedge clock);
    #1;
    borda++;
    if (jogada_pulso) begin
      n_jog++;
      ult_jog = borda;
    end
    if (db_multipla) n_mult++;
    if (jogada_pulso && db_multipla) n_overlap++;
    if (db_estado > 4'd3) n_est_bad++;
  endtask

  function automatic seg_t seg(input logic [3:0] raw, input int rep, input int jog,
                               input int mult, input logic [3:0] out, input logic tem,
                               input logic [3:0] est);
    seg_t s;
    s.raw = raw; s.rep = rep; s.jog = jog; s.mult = mult;
    s.out = out; s.tem = tem; s.est = est;
    return s;
  endfunction

  initial begin
    int b0;
    int t_low;
    seg_t e;
    logic [3:0] est_lib [9];
    logic [3:0] raw_lib [9];

    // Rows continue from the state left by the clean-press sequence (idle, out=0010).
    tabela[0]  = seg(4'b0100,  1, 0, 0, 4'b0010, 1'b0, 4'd0);
    tabela[1]  = seg(4'b0000,  1, 0, 0, 4'b0010, 1'b0, 4'd0);
    tabela[2]  = seg(4'b0100,  1, 0, 0, 4'b0010, 1'b0, 4'd1);
    tabela[3]  = seg(4'b0000,  1, 0, 0, 4'b0010, 1'b0, 4'd0);
    tabela[4]  = seg(4'b0100,  1, 0, 0, 4'b0010, 1'b0, 4'd1);
    tabela[5]  = seg(4'b0000,  1, 0, 0, 4'b0010, 1'b0, 4'd0);
    tabela[6]  = seg(4'b0100, 20, 1, 0, 4'b0100, 1'b1, 4'd2);
    tabela[7]  = seg(4'b0000, 20, 0, 0, 4'b0100, 1'b0, 4'd0);
    tabela[8]  = seg(4'b1001, 20, 0, 1, 4'b0100, 1'b1, 4'd2);
    tabela[9]  = seg(4'b0000, 20, 0, 0, 4'b0100, 1'b0, 4'd0);
    tabela[10] = seg(4'b0001, 20, 1, 0, 4'b0001, 1'b1, 4'd2);
    tabela[11] = seg(4'b0011, 10, 0, 0, 4'b0001, 1'b1, 4'd2);
    tabela[12] = seg(4'b1000, 10, 0, 0, 4'b0001, 1'b1, 4'd2);
    tabela[13] = seg(4'b0000, 20, 0, 0, 4'b0001, 1'b0, 4'd0);
    tabela[14] = seg(4'b1000, 20, 1, 0, 4'b1000, 1'b1, 4'd2);
    tabela[15] = seg(4'b0000, 20, 0, 0, 4'b1000, 1'b0, 4'd0);

    raw_lib = '{4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000,
                4'b0000, 4'b0000, 4'b0000, 4'b0000};
    est_lib = '{4'd2, 4'd2, 4'd3, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd0};

    // Reset state
    repeat (3) ciclo(1'b1, 4'b0000);
    checar("reset botoes_out", int'(botoes_out), 0);
    checar("reset jogada_pulso", int'(jogada_pulso), 0);
    checar("reset db_multipla", int'(db_multipla), 0);
    checar("reset tem_botao", int'(tem_botao), 0);
    checar("reset db_estado", int'(db_estado), 0);

    // Clean press: pulse exactly 7 edges after first sample
    n_jog = 0; b0 = borda;
    repeat (20) ciclo(1'b0, 4'b0010);
    checar("limpo n_pulsos", n_jog, 1);
    checar("limpo latencia", ult_jog - b0, 7);
    checar("limpo botoes_out", int'(botoes_out), 2);
    checar("limpo tem_botao", int'(tem_botao), 1);
    b0 = borda; t_low = -1;
    for (int i = 0; i < 20; i++) begin
      ciclo(1'b0, 4'b0000);
      if (!tem_botao && t_low < 0) t_low = borda - b0;
    end
    checar("limpo tem_botao queda", t_low, 7);
    checar("limpo out mantido", int'(botoes_out), 2);
    checar("limpo estado final", int'(db_estado), 0);

    // Table: bounce, multiple press, hold-and-change
    for (int i = 0; i < N_SEG; i++) begin
      fila.push_back(tabela[i]);
      n_jog = 0; n_mult = 0;
      for (int c = 0; c < tabela[i].rep; c++) ciclo(1'b0, tabela[i].raw);
      e = fila.pop_front();
      checar($sformatf("seg%0d jogada", i), n_jog, e.jog);
      checar($sformatf("seg%0d multipla", i), n_mult, e.mult);
      checar($sformatf("seg%0d botoes_out", i), int'(botoes_out), int'(e.out));
      checar($sformatf("seg%0d tem_botao", i), int'(tem_botao), int'(e.tem));
      checar($sformatf("seg%0d db_estado", i), int'(db_estado), int'(e.est));
    end

    // Release bounce after an accepted press
    n_jog = 0;
    repeat (20) ciclo(1'b0, 4'b0010);
    checar("rebote press pulso", n_jog, 1);
    checar("rebote press out", int'(botoes_out), 2);
    n_jog = 0;
    for (int i = 0; i < 9; i++) begin
      ciclo(1'b0, raw_lib[i]);
      checar($sformatf("rebote estado[%0d]", i), int'(db_estado), int'(est_lib[i]));
    end
    checar("rebote sem pulso", n_jog, 0);

    // Reset in the middle of filtering
    repeat (3) ciclo(1'b0, 4'b0001);
    checar("rst filtrando estado", int'(db_estado), 1);
    n_jog = 0; n_mult = 0;
    ciclo(1'b1, 4'b0001);
    checar("rst botoes_out", int'(botoes_out), 0);
    checar("rst jogada_pulso", n_jog, 0);
    checar("rst db_multipla", n_mult, 0);
    checar("rst tem_botao", int'(tem_botao), 0);
    checar("rst db_estado", int'(db_estado), 0);
    b0 = borda;
    repeat (20) ciclo(1'b0, 4'b0001);
    checar("pos-rst n_pulsos", n_jog, 1);
    checar("pos-rst latencia", ult_jog - b0, 7);
    checar("pos-rst botoes_out", int'(botoes_out), 1);
    repeat (10) ciclo(1'b0, 4'b0000);
    checar("pos-rst liberado", int'(db_estado), 0);

    checar("pulsos sobrepostos", n_overlap, 0);
    checar("estado indefinido", n_est_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
